// File: rtl/id_stage_pkg.sv
// RV32I types shared by the decode stage: opcodes, ALU/compare ops and the IF/ID and ID/EX bundles.
package id_stage_pkg;

  typedef enum logic [6:0] {
    OpLui   = 7'b0110111,
    OpAuipc = 7'b0010111,
    OpJal   = 7'b1101111,
    OpJalr  = 7'b1100111,
    OpBr    = 7'b1100011,
    OpLoad  = 7'b0000011,
    OpStore = 7'b0100011,
    OpImm   = 7'b0010011,
    OpReg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSll = 3'b001,
    AluSra = 3'b010,
    AluSub = 3'b011,
    AluXor = 3'b100,
    AluSrl = 3'b101,
    AluOr  = 3'b110,
    AluAnd = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    CmpBeq  = 3'b000,
    CmpBne  = 3'b001,
    CmpBlt  = 3'b100,
    CmpBge  = 3'b101,
    CmpBltu = 3'b110,
    CmpBgeu = 3'b111
  } cmp_op_t;

  typedef enum logic {M1Rs1 = 1'b0, M1Pc = 1'b1} m1_sel_t;
  typedef enum logic {M2Imm = 1'b0, M2Rs2 = 1'b1} m2_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        illegal;
    logic [31:0] imm;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    alu_op_t     alu_op;
    cmp_op_t     cmp_op;
    m1_sel_t     alu_m1_sel;
    m2_sel_t     alu_m2_sel;
    logic        regf_we;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
  } id_ex_t;

  // SLT/SLTU compute through the comparator, so the ALU op for them is a don't-care add.
  function automatic alu_op_t funct3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      3'b111:  op = AluAnd;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

  function automatic cmp_op_t funct3_to_cmp(input logic [2:0] f3);
    cmp_op_t op;
    case (f3)
      3'b001:  op = CmpBne;
      3'b010:  op = CmpBlt;
      3'b011:  op = CmpBltu;
      3'b100:  op = CmpBlt;
      3'b101:  op = CmpBge;
      3'b110:  op = CmpBltu;
      3'b111:  op = CmpBgeu;
      default: op = CmpBeq;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Pipeline-side signals of the decode stage. master = surrounding pipeline, slave = id_stage.
interface id_stage_if;
  import id_stage_pkg::*;

  if_id_t      if_id;
  logic        stall_signal;
  logic        flushing_inst;
  logic        wb_regf_we;
  logic [4:0]  wb_rd_s;
  logic [31:0] wb_rd_v;
  logic        load_use_stall;
  id_ex_t      id_ex;

  modport master (
    output if_id, stall_signal, flushing_inst, wb_regf_we, wb_rd_s, wb_rd_v,
    input  load_use_stall, id_ex
  );

  modport slave (
    input  if_id, stall_signal, flushing_inst, wb_regf_we, wb_rd_s, wb_rd_v,
    output load_use_stall, id_ex
  );

endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 2R/1W register file; x0 is hardwired to zero, optional write-through on same-cycle reads.
module id_stage_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  rd_s,
  input  logic [31:0] rd_v,
  input  logic [4:0]  rs1_s,
  input  logic [4:0]  rs2_s,
  output logic [31:0] rs1_v,
  output logic [31:0] rs2_v
);

  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = we && (rd_s != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd_s] <= rd_v;
    end
  end

  always_comb begin
    rs1_v = (rs1_s == 5'd0) ? 32'd0 : regs_q[rs1_s];
    rs2_v = (rs2_s == 5'd0) ? 32'd0 : regs_q[rs2_s];
    if (BYPASS && wr_en && (rd_s == rs1_s)) rs1_v = rd_v;
    if (BYPASS && wr_en && (rd_s == rs2_s)) rs2_v = rd_v;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediate generation, register read, load-use detection and
// the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter bit REG_BYPASS = 1'b1,
  parameter bit LU_DETECT  = 1'b1
) (
  input logic     clk,
  input logic     rst,
  id_stage_if.slave pipe
);

  logic [31:0] inst;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_v, rs2_v;
  logic        load_use;
  id_ex_t      dec;
  id_ex_t      bundle;
  id_ex_t      id_ex_d, id_ex_q;

  assign inst  = pipe.if_id.inst;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec            = '0;
    rs1_used       = 1'b0;
    rs2_used       = 1'b0;
    dec.pc         = pipe.if_id.pc;
    dec.inst       = inst;
    dec.valid      = pipe.if_id.valid;
    dec.funct3     = inst[14:12];
    dec.alu_op     = AluAdd;
    dec.cmp_op     = CmpBeq;
    dec.alu_m1_sel = M1Rs1;
    dec.alu_m2_sel = M2Imm;
    case (rv32i_opcode'(inst[6:0]))
      OpLui: begin
        dec.imm     = imm_u;
        dec.regf_we = 1'b1;
      end
      OpAuipc: begin
        dec.imm        = imm_u;
        dec.alu_m1_sel = M1Pc;
        dec.regf_we    = 1'b1;
      end
      OpJal: begin
        dec.imm        = imm_j;
        dec.alu_m1_sel = M1Pc;
        dec.regf_we    = 1'b1;
        dec.is_jal     = 1'b1;
      end
      OpJalr: begin
        dec.imm     = imm_i;
        rs1_used    = 1'b1;
        dec.regf_we = 1'b1;
        dec.is_jalr = 1'b1;
      end
      OpBr: begin
        dec.imm        = imm_b;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        dec.alu_m1_sel = M1Pc;
        dec.cmp_op     = funct3_to_cmp(inst[14:12]);
        dec.is_branch  = 1'b1;
      end
      OpLoad: begin
        dec.imm      = imm_i;
        rs1_used     = 1'b1;
        dec.regf_we  = 1'b1;
        dec.mem_read = 1'b1;
      end
      OpStore: begin
        dec.imm       = imm_s;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        dec.mem_write = 1'b1;
      end
      OpImm: begin
        dec.imm     = imm_i;
        rs1_used    = 1'b1;
        dec.regf_we = 1'b1;
        // Only SRAI uses inst[30]; for ADDI it is an immediate bit.
        dec.alu_op  = funct3_to_alu(inst[14:12], inst[30] && (inst[14:12] == 3'b101));
        dec.cmp_op  = funct3_to_cmp(inst[14:12]);
      end
      OpReg: begin
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        dec.alu_m2_sel = M2Rs2;
        dec.regf_we    = 1'b1;
        dec.alu_op     = funct3_to_alu(inst[14:12], inst[30]);
        dec.cmp_op     = funct3_to_cmp(inst[14:12]);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rs1_s = rs1_used ? inst[19:15] : 5'd0;
    dec.rs2_s = rs2_used ? inst[24:20] : 5'd0;
    dec.rd_s  = dec.regf_we ? inst[11:7] : 5'd0;
    if (!pipe.if_id.valid) begin
      dec.regf_we   = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jal    = 1'b0;
      dec.is_jalr   = 1'b0;
    end
  end

  id_stage_regfile #(
    .BYPASS(REG_BYPASS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (pipe.wb_regf_we),
    .rd_s  (pipe.wb_rd_s),
    .rd_v  (pipe.wb_rd_v),
    .rs1_s (dec.rs1_s),
    .rs2_s (dec.rs2_s),
    .rs1_v (rs1_v),
    .rs2_v (rs2_v)
  );

  always_comb begin
    bundle       = dec;
    bundle.rs1_v = rs1_v;
    bundle.rs2_v = rs2_v;
  end

  assign load_use = LU_DETECT && pipe.if_id.valid && id_ex_q.valid && id_ex_q.mem_read &&
                    (id_ex_q.rd_s != 5'd0) &&
                    ((rs1_used && (dec.rs1_s == id_ex_q.rd_s)) ||
                     (rs2_used && (dec.rs2_s == id_ex_q.rd_s)));

  always_comb begin
    id_ex_d = id_ex_q;
    if (pipe.flushing_inst) begin
      id_ex_d = '0;
    end else if (pipe.stall_signal) begin
      id_ex_d = id_ex_q;
    end else if (load_use) begin
      id_ex_d = '0;
    end else begin
      id_ex_d = bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign pipe.id_ex          = id_ex_q;
  assign pipe.load_use_stall = load_use;

endmodule
